// File: rtl/mme_apb_regfile.sv
// APB completer for the MME configuration/control registers.
// Drives matrix width, A/B/C base addresses and a start pulse; latches engine completion.
module mme_apb_regfile #(
  parameter logic [31:0] IP_VERSION  = 32'h0001_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [15:0] mat_width,
  output logic [31:0] mat_a_addr,
  output logic [31:0] mat_b_addr,
  output logic [31:0] mat_c_addr,
  output logic        start,
  input  logic        done
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [15:0] cfg_q, cfg_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic        start_pend_q, start_pend_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_bit_q, done_bit_d;
  logic        busy_eff;
  logic [9:0]  word;
  logic        unused_addr_lsb;

  assign word            = paddr[11:2];
  assign unused_addr_lsb = ^paddr[1:0];
  // A completion arriving on the deciding edge frees the engine before the error check.
  assign busy_eff        = busy_q & ~done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prdata_d     = 32'h0;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    cfg_d        = cfg_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    start_pend_d = 1'b0;
    start_d      = 1'b0;
    busy_d       = busy_q;
    done_bit_d   = done_bit_q;

    if (done && busy_q) begin
      busy_d     = 1'b0;
      done_bit_d = 1'b1;
    end
    if (start_pend_q) begin
      start_d    = 1'b1;
      busy_d     = 1'b1;
      done_bit_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LD;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d  = IDLE;
            pready_d = 1'b1;
            case (word)
              10'h000: begin
                if (pwrite) pslverr_d = 1'b1;
                else        prdata_d  = IP_VERSION;
              end
              10'h040: begin
                if (!pwrite)       prdata_d  = {16'h0, cfg_q};
                else if (busy_eff) pslverr_d = 1'b1;
                else               cfg_d     = pwdata[15:0];
              end
              10'h080: begin
                if (!pwrite)       prdata_d  = a_q;
                else if (busy_eff) pslverr_d = 1'b1;
                else               a_d       = pwdata;
              end
              10'h081: begin
                if (!pwrite)       prdata_d  = b_q;
                else if (busy_eff) pslverr_d = 1'b1;
                else               b_d       = pwdata;
              end
              10'h082: begin
                if (!pwrite)       prdata_d  = c_q;
                else if (busy_eff) pslverr_d = 1'b1;
                else               c_d       = pwdata;
              end
              10'h083: begin
                if (pwrite && pwdata[0]) begin
                  if (busy_eff) pslverr_d    = 1'b1;
                  else          start_pend_d = 1'b1;
                end
              end
              10'h084: begin
                if (pwrite) pslverr_d = 1'b1;
                else        prdata_d  = {30'h0, busy_q, done_bit_q};
              end
              default: pslverr_d = 1'b1;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      prdata_q     <= 32'h0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      cfg_q        <= 16'h0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      c_q          <= 32'h0;
      start_pend_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prdata_q     <= prdata_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      cfg_q        <= cfg_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      start_pend_q <= start_pend_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_bit_q   <= done_bit_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign mat_width  = cfg_q;
  assign mat_a_addr = a_q;
  assign mat_b_addr = b_q;
  assign mat_c_addr = c_q;
  assign start      = start_q;

endmodule

// File: tb/tb_mme_apb_regfile.sv
// Directed bench for mme_apb_regfile: zero-wait instance plus a WAIT_CYCLES=3 instance.
module tb_mme_apb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = 12'h0;
  logic [31:0] pwdata = 32'h0;
  logic        done = 1'b0;
  logic        sel3 = 1'b0;

  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3, start0, start3;
  logic [15:0] w0, w3;
  logic [31:0] a0, b0, c0, a3, b3, c3;

  int total = 0;
  int passed = 0;
  int sc0 = 0;

  always #5 clk = ~clk;

  mme_apb_regfile #(.IP_VERSION(32'h0001_0000), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .psel(psel & ~sel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .mat_width(w0), .mat_a_addr(a0), .mat_b_addr(b0), .mat_c_addr(c0),
    .start(start0), .done(done));

  mme_apb_regfile #(.IP_VERSION(32'h0001_0000), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .psel(psel & sel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .mat_width(w3), .mat_a_addr(a3), .mat_b_addr(b3), .mat_c_addr(c3),
    .start(start3), .done(done));

  always @(negedge clk) if (start0) sc0 <= sc0 + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d, input bit pdone,
                     output logic [31:0] rd, output logic err, output int lat);
    bit rdy;
    rdy = 1'b0;
    lat = 0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    if (pdone) done = 1'b1;
    for (int i = 0; i < 40 && !rdy; i++) begin
      @(posedge clk); #1;
      done = 1'b0;
      lat++;
      rdy = sel3 ? pready3 : pready0;
    end
    rd  = sel3 ? prdata3 : prdata0;
    err = sel3 ? pslverr3 : pslverr0;
    if (!rdy) begin
      total++;
      $error("FAIL pready_timeout observed=0 expected=1");
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          sc_before;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("rst_pready", {31'h0, pready0}, 32'h0);
    chk("rst_prdata", prdata0, 32'h0);
    apb(0, 12'h000, 0, 0, rd, err, lat);
    chk("ipver_rd", rd, 32'h0001_0000);
    chk("ipver_err", {31'h0, err}, 32'h0);
    chk("lat_w0", lat, 1);
    apb(0, 12'h210, 0, 0, rd, err, lat);
    chk("status_rst", rd, 32'h0);
    chk("start_rst", sc0, 0);

    // 2: configuration writes and read-back
    apb(1, 12'h100, 32'hABCD_0008, 0, rd, err, lat);
    chk("cfg_wr_err", {31'h0, err}, 32'h0);
    chk("wr_prdata0", rd, 32'h0);
    apb(1, 12'h200, 32'h0, 0, rd, err, lat);
    apb(1, 12'h204, 32'h1000, 0, rd, err, lat);
    apb(1, 12'h208, 32'h2000, 0, rd, err, lat);
    apb(0, 12'h100, 0, 0, rd, err, lat);
    chk("cfg_rd", rd, 32'h0000_0008);
    apb(0, 12'h200, 0, 0, rd, err, lat);
    chk("a_rd", rd, 32'h0);
    apb(0, 12'h204, 0, 0, rd, err, lat);
    chk("b_rd", rd, 32'h1000);
    apb(0, 12'h208, 0, 0, rd, err, lat);
    chk("c_rd", rd, 32'h2000);
    chk("mat_width", {16'h0, w0}, 32'h8);
    chk("mat_b", b0, 32'h1000);
    chk("mat_c", c0, 32'h2000);

    // 3: start, busy protection, completion
    sc_before = sc0;
    apb(1, 12'h20C, 32'h1, 0, rd, err, lat);
    chk("cmd_err", {31'h0, err}, 32'h0);
    repeat (4) @(negedge clk);
    chk("start_once", sc0 - sc_before, 1);
    apb(0, 12'h210, 0, 0, rd, err, lat);
    chk("status_busy", rd, 32'h2);
    apb(1, 12'h204, 32'h3000, 0, rd, err, lat);
    chk("busy_wr_err", {31'h0, err}, 32'h1);
    apb(0, 12'h204, 0, 0, rd, err, lat);
    chk("busy_wr_kept", rd, 32'h1000);
    sc_before = sc0;
    apb(1, 12'h20C, 32'h1, 0, rd, err, lat);
    chk("busy_cmd_err", {31'h0, err}, 32'h1);
    repeat (3) @(negedge clk);
    chk("busy_cmd_nostart", sc0 - sc_before, 0);
    pulse_done();
    apb(0, 12'h210, 0, 0, rd, err, lat);
    chk("status_done", rd, 32'h1);
    apb(1, 12'h20C, 32'h0, 0, rd, err, lat);
    chk("cmd0_err", {31'h0, err}, 32'h0);
    apb(0, 12'h210, 0, 0, rd, err, lat);
    chk("cmd0_status", rd, 32'h1);

    // 4: error responses and wait states
    apb(0, 12'h300, 0, 0, rd, err, lat);
    chk("unmapped_err", {31'h0, err}, 32'h1);
    chk("unmapped_rd", rd, 32'h0);
    apb(1, 12'h000, 32'h5, 0, rd, err, lat);
    chk("ipver_wr_err", {31'h0, err}, 32'h1);
    apb(1, 12'h210, 32'h3, 0, rd, err, lat);
    chk("status_wr_err", {31'h0, err}, 32'h1);
    apb(0, 12'h000, 0, 0, rd, err, lat);
    chk("ipver_kept", rd, 32'h0001_0000);
    sel3 = 1'b1;
    apb(0, 12'h300, 0, 0, rd, err, lat);
    chk("w3_unmapped_err", {31'h0, err}, 32'h1);
    chk("w3_lat", lat, 4);
    apb(1, 12'h208, 32'h0000_BEEF, 0, rd, err, lat);
    chk("w3_wr_lat", lat, 4);
    chk("w3_mat_c", c3, 32'h0000_BEEF);
    sel3 = 1'b0;

    // 5: done coincident with the deciding edge of a start while busy
    apb(1, 12'h20C, 32'h1, 0, rd, err, lat);
    repeat (2) @(negedge clk);
    sc_before = sc0;
    apb(1, 12'h20C, 32'h1, 1, rd, err, lat);
    chk("coinc_err", {31'h0, err}, 32'h0);
    repeat (3) @(negedge clk);
    chk("coinc_start", sc0 - sc_before, 1);
    apb(0, 12'h210, 0, 0, rd, err, lat);
    chk("coinc_status", rd, 32'h2);

    // 6: reset in the access phase abandons the transfer
    pulse_done();
    apb(1, 12'h200, 32'hCAFE_0000, 0, rd, err, lat);
    chk("a_pre_rst", a0, 32'hCAFE_0000);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h200; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_pready", {31'h0, pready0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_pready2", {31'h0, pready0}, 32'h0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("rst_mat_a", a0, 32'h0);
    apb(0, 12'h210, 0, 0, rd, err, lat);
    chk("rst_status", rd, 32'h0);
    apb(1, 12'h200, 32'h77, 0, rd, err, lat);
    chk("post_rst_err", {31'h0, err}, 32'h0);
    apb(0, 12'h200, 0, 0, rd, err, lat);
    chk("post_rst_rd", rd, 32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mme_apb_regfile.md
Name: mme_apb_regfile

Overview:
APB completer (slave) holding the MME configuration and control registers. It responds to the host-side APB requester, which configures the matrix engine and polls it. It drives matrix width, A/B/C base addresses and a one-cycle start pulse into the MME datapath, and latches the engine's completion into a pollable status register. It is the responder end of the APB link that software and the bench drive.

Parameters:
IP_VERSION, 32'h0001_0000, value returned by IP_VER register
WAIT_CYCLES, 0, extra access-phase cycles before pready (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1=write, 0=read
paddr  in  12  byte address; bits[1:0] ignored
pwdata  in  32  write data
prdata  out  32  read data; valid when pready=1
pready  out  1  transfer completion
pslverr  out  1  error response; valid when pready=1
mat_width  out  16  MAT_CFG[15:0]
mat_a_addr  out  32  A base address
mat_b_addr  out  32  B base address
mat_c_addr  out  32  C base address
start  out  1  one-cycle start pulse to engine
done  in  1  one-cycle completion pulse from engine

Behaviour:
- Reset (rst=1 at posedge clk):
  - all registers, prdata, pready, pslverr, start are cleared to 0; busy and done status bits are cleared.
  - Any in-flight APB transfer is abandoned; no pready is issued for it.
- Register map (all other offsets are unmapped):
  - 0x000 IP_VER: RO, returns IP_VERSION.
  - 0x100 MAT_CFG: RW, bits[15:0] stored; bits[31:16] read 0.
  - 0x200 MAT_A_ADDR, 0x204 MAT_B_ADDR, 0x208 MAT_C_ADDR: RW, full 32 bits stored.
  - 0x20C MME_CMD: WO. A write with bit0=1 requests start. Reads return 0.
  - 0x210 MME_STATUS: RO. bit0=done, bit1=busy, other bits 0.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel=1 & penable=0 (setup). The wait counter loads WAIT_CYCLES.
  - In ACCESS with psel & penable: decrement the counter each cycle. When it reaches 0, drive pready=1 for exactly one cycle, with prdata/pslverr valid in that same cycle. Return to IDLE next cycle.
  - Back-to-back: a new setup may follow directly after the pready cycle.
- Write side effects occur only on the pready cycle. Reads have no side effects.
- pslverr=1 cases; in every case the registers are unchanged:
  - access to an unmapped offset;
  - write to IP_VER or MME_STATUS;
  - write to MAT_CFG or any ADDR register while busy=1;
  - MME_CMD write with bit0=1 while busy=1 (no start is issued).
- Start: an accepted MME_CMD bit0=1 write produces start=1 on the cycle after the pready cycle. The same edge sets busy=1 and clears done=0.
- Completion: done=1 with busy=1 clears busy and sets the done bit, which stays set until the next accepted start. done while busy=0 is ignored.
- Simultaneous done and MME_CMD pready cycle: done is applied first. busy is evaluated as 0, so the start is accepted without error.
- MME_CMD write with bit0=0: no effect, pslverr=0.
- prdata is 0 whenever pready=0.
- Outputs mat_* reflect the stored registers combinationally from the flops, with no extra latency after the write edge.

Test Plan:
1. After reset, read 0x000 -> prdata=32'h0001_0000, pslverr=0. Read 0x210 -> 0. start remains 0.
2. Write 0x100=8, 0x200=0, 0x204=0x1000, 0x208=0x2000, each read back -> values match. mat_width=8, mat_b_addr=0x1000, mat_c_addr=0x2000.
3. Write 0x20C=1 -> start high exactly 1 cycle, and status reads 0x2. Then write 0x204=0x3000 -> pslverr=1 and the register is still 0x1000. Pulse done -> status reads 0x1.
4. Read 0x300 and write 0x000=5 -> pslverr=1 on both, IP_VER unchanged. With WAIT_CYCLES=3, pready arrives exactly 4 cycles after penable rises.
5. done pulse in the same cycle as the pready of a 0x20C=1 write while busy -> pslverr=0, start pulses, status=0x2.
6. Assert rst during the ACCESS phase of a 0x200 write -> no pready, mat_a_addr=0, status=0. The next transaction completes normally.
